axi_read_data_channel_checked: RTL and testbench

//  Parametrised AXI4 R-channel receiver for one outstanding read burst.

---
 rtl/axi_read_data_channel_checked.sv | 124 ++++++++++++
 tb/tb_axi_read_data_channel_checked.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_data_channel_checked.sv
// axi_read_data_channel_checked: AXI4 R-channel receiver for one outstanding burst.
// Forwards good beats to a FIFO, checks RID/RRESP/RLAST/beat count, drains after errors, times out on stalls.
module axi_read_data_channel_checked #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic                  i_go,
    input  logic [ID_WIDTH-1:0]   i_exp_id,
    input  logic [LEN_WIDTH-1:0]  i_exp_len,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    input  logic                  i_fifo_ready,
    output logic                  o_last_transfer,
    output logic [LEN_WIDTH:0]    o_beat_count,
    output logic                  o_done,
    output logic                  o_error,
    output logic [2:0]            o_err_code,
    output logic [ID_WIDTH-1:0]   o_transaction_id,
    input  logic [ID_WIDTH-1:0]   i_rid,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]            i_rresp,
    input  logic                  i_rlast,
    input  logic                  i_rvalid,
    output logic                  o_rready
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACTIVE = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64 && DATA_WIDTH != 128 &&
        DATA_WIDTH != 256 && DATA_WIDTH != 512) begin : g_bad_width
        $error("axi_read_data_channel_checked: illegal DATA_WIDTH");
    end

    logic [2:0]           r_state;
    logic [ID_WIDTH-1:0]  r_id;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH:0]   r_beat_count;
    logic [TW-1:0]        r_timer;
    logic [2:0]           r_err_code;
    logic                 w_active;
    logic                 w_drain;
    logic                 w_hs;
    logic                 w_timeout;
    logic                 w_good;
    logic [2:0]           w_code;

    assign w_active = (r_state == S_ACTIVE);
    assign w_drain  = (r_state == S_DRAIN);
    assign o_rready = w_active ? i_fifo_ready : w_drain;
    assign w_hs     = i_rvalid & o_rready;
    // Timer holds TIMEOUT-1 on the last tolerated stall cycle; the next stall cycle fires.
    assign w_timeout = (TIMEOUT > 0) && !i_rvalid && (r_timer == TW'(TIMEOUT - 1));

    always_comb begin
        w_code = (i_rid != r_id) ? 3'd2 :
                 (i_rresp != 2'b00) ? 3'd1 :
                 (i_rlast && r_beat_count < {1'b0, r_len}) ? 3'd3 :
                 (!i_rlast && r_beat_count == {1'b0, r_len}) ? 3'd4 : 3'd0;
    end

    assign w_good           = w_active & w_hs & (w_code == 3'd0);
    assign o_data           = i_rdata;
    assign o_data_valid     = w_good;
    assign o_last_transfer  = w_good & i_rlast;
    assign o_beat_count     = r_beat_count;
    assign o_done           = (r_state == S_DONE);
    assign o_error          = (r_state == S_ERROR);
    assign o_err_code       = r_err_code;
    assign o_transaction_id = r_id;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn)
            r_timer <= '0;
        else
            r_timer <= (!(w_active || w_drain) || w_hs) ? '0 : !i_rvalid ? r_timer + 1'b1 : r_timer;
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state      <= S_IDLE;
            r_id         <= '0;
            r_len        <= '0;
            r_beat_count <= '0;
            r_err_code   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_go) begin
                    r_state      <= S_ACTIVE;
                    r_id         <= i_exp_id;
                    r_len        <= i_exp_len;
                    r_beat_count <= '0;
                    r_err_code   <= '0;
                end
                S_ACTIVE: if (w_hs) begin
                    if (w_code == 3'd0) begin
                        r_beat_count <= r_beat_count + 1'b1;
                        if (i_rlast) r_state <= S_DONE;
                    end else begin
                        r_err_code <= w_code;
                        r_state    <= i_rlast ? S_ERROR : S_DRAIN;
                    end
                end else if (w_timeout) begin
                    r_err_code <= 3'd5;
                    r_state    <= S_ERROR;
                end
                S_DRAIN: if ((w_hs && i_rlast) || w_timeout) r_state <= S_ERROR;
                S_DONE, S_ERROR: if (!i_go) begin
                    r_state    <= S_IDLE;
                    r_id       <= '0;
                    r_err_code <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_read_data_channel_checked.sv
// tb_axi_read_data_channel_checked: directed checks of the R-channel receiver with TIMEOUT=16.
module tb_axi_read_data_channel_checked;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        go = 1'b0;
    logic [3:0]  exp_id = '0;
    logic [7:0]  exp_len = '0;
    logic [31:0] data;
    logic        data_valid;
    logic        fifo_ready = 1'b0;
    logic        last_transfer;
    logic [8:0]  beat_count;
    logic        done;
    logic        error;
    logic [2:0]  err_code;
    logic [3:0]  transaction_id;
    logic [3:0]  rid = '0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;
    int compared = 0;
    int mismatched = 0;

    axi_read_data_channel_checked #(
        .DATA_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(8), .TIMEOUT(16)
    ) dut (
        .i_clk(clk), .i_resetn(resetn), .i_go(go), .i_exp_id(exp_id), .i_exp_len(exp_len),
        .o_data(data), .o_data_valid(data_valid), .i_fifo_ready(fifo_ready),
        .o_last_transfer(last_transfer), .o_beat_count(beat_count), .o_done(done),
        .o_error(error), .o_err_code(err_code), .o_transaction_id(transaction_id),
        .i_rid(rid), .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast),
        .i_rvalid(rvalid), .o_rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_beat(input string tag, input logic [3:0] id, input logic [31:0] d,
                           input logic [1:0] resp, input logic last, input logic ev, input logic el);
        rid = id; rdata = d; rresp = resp; rlast = last; rvalid = 1'b1;
        #1;
        chk({tag, "_dv"}, data_valid, ev);
        chk({tag, "_last"}, last_transfer, el);
        if (ev) chk({tag, "_data"}, data, d);
        tick();
    endtask

    task automatic start(input logic [3:0] id, input logic [7:0] len);
        exp_id = id; exp_len = len; go = 1'b1;
        tick();
    endtask

    task automatic finish_txn(input string tag);
        rvalid = 1'b0; rlast = 1'b0; go = 1'b0;
        tick();
        chk({tag, "_idle_done"}, done, 1'b0);
        chk({tag, "_idle_error"}, error, 1'b0);
        chk({tag, "_idle_tid"}, transaction_id, 4'd0);
        chk({tag, "_idle_code"}, err_code, 3'd0);
    endtask

    initial begin
        tick(); tick();
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_dv", data_valid, 1'b0);
        chk("rst_beats", beat_count, 9'd0);
        chk("rst_tid", transaction_id, 4'd0);
        chk("rst_code", err_code, 3'd0);
        resetn = 1'b1;
        tick();

        // T1: clean 4-beat burst
        fifo_ready = 1'b1;
        exp_id = 4'd3; exp_len = 8'd3; go = 1'b1;
        #1;
        chk("t1_idle_rready", rready, 1'b0);
        tick();
        chk("t1_tid", transaction_id, 4'd3);
        chk("t1_rready", rready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            do_beat("t1_beat", 4'd3, 32'hA000 + i, 2'b00, i == 3, 1'b1, i == 3);
            chk("t1_count", beat_count, 9'(i + 1));
        end
        rvalid = 1'b0; rlast = 1'b0;
        chk("t1_done", done, 1'b1);
        chk("t1_code", err_code, 3'd0);
        chk("t1_done_rready", rready, 1'b0);
        finish_txn("t1");
        chk("t1_held_beats", beat_count, 9'd4);

        // T2: downstream stall of 5 cycles mid-burst
        start(4'd3, 8'd3);
        do_beat("t2_b0", 4'd3, 32'hB000, 2'b00, 1'b0, 1'b1, 1'b0);
        do_beat("t2_b1", 4'd3, 32'hB001, 2'b00, 1'b0, 1'b1, 1'b0);
        fifo_ready = 1'b0;
        rid = 4'd3; rdata = 32'hB002; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2_stall_rready", rready, 1'b0);
            chk("t2_stall_dv", data_valid, 1'b0);
            tick();
        end
        chk("t2_stall_error", error, 1'b0);
        chk("t2_stall_count", beat_count, 9'd2);
        fifo_ready = 1'b1;
        do_beat("t2_b2", 4'd3, 32'hB002, 2'b00, 1'b0, 1'b1, 1'b0);
        do_beat("t2_b3", 4'd3, 32'hB003, 2'b00, 1'b1, 1'b1, 1'b1);
        chk("t2_done", done, 1'b1);
        chk("t2_count", beat_count, 9'd4);
        finish_txn("t2");

        // T3: SLVERR on beat 3 of 8, drain the rest
        start(4'd2, 8'd7);
        do_beat("t3_b1", 4'd2, 32'hC001, 2'b00, 1'b0, 1'b1, 1'b0);
        do_beat("t3_b2", 4'd2, 32'hC002, 2'b00, 1'b0, 1'b1, 1'b0);
        do_beat("t3_b3", 4'd2, 32'hC003, 2'b10, 1'b0, 1'b0, 1'b0);
        chk("t3_code", err_code, 3'd1);
        fifo_ready = 1'b0;
        for (int i = 4; i < 8; i++) begin
            #1;
            chk("t3_drain_rready", rready, 1'b1);
            do_beat("t3_drain", 4'd2, 32'hC000 + i, 2'b00, 1'b0, 1'b0, 1'b0);
        end
        chk("t3_not_error_yet", error, 1'b0);
        do_beat("t3_b8", 4'd2, 32'hC008, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("t3_error", error, 1'b1);
        chk("t3_code_held", err_code, 3'd1);
        chk("t3_count", beat_count, 9'd2);
        chk("t3_err_rready", rready, 1'b0);
        fifo_ready = 1'b1;
        finish_txn("t3");

        // T4a: wrong RID on first beat
        start(4'd5, 8'd3);
        do_beat("t4a_b1", 4'd6, 32'hD001, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("t4a_code", err_code, 3'd2);
        chk("t4a_drain_rready", rready, 1'b1);
        do_beat("t4a_b2", 4'd6, 32'hD002, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("t4a_error", error, 1'b1);
        chk("t4a_count", beat_count, 9'd0);
        finish_txn("t4a");

        // T4b: early RLAST on beat 2 of 4
        start(4'd5, 8'd3);
        do_beat("t4b_b1", 4'd5, 32'hE001, 2'b00, 1'b0, 1'b1, 1'b0);
        do_beat("t4b_b2", 4'd5, 32'hE002, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("t4b_error", error, 1'b1);
        chk("t4b_code", err_code, 3'd3);
        chk("t4b_count", beat_count, 9'd1);
        finish_txn("t4b");

        // T4c: missing RLAST on final beat of a 2-beat burst
        start(4'd1, 8'd1);
        do_beat("t4c_b1", 4'd1, 32'hF001, 2'b00, 1'b0, 1'b1, 1'b0);
        do_beat("t4c_b2", 4'd1, 32'hF002, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("t4c_code", err_code, 3'd4);
        chk("t4c_count", beat_count, 9'd1);
        do_beat("t4c_b3", 4'd1, 32'hF003, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("t4c_error", error, 1'b1);
        chk("t4c_count_final", beat_count, 9'd1);
        finish_txn("t4c");

        // T5: timeout after 16 stalled cycles
        rvalid = 1'b0;
        start(4'd9, 8'd0);
        chk("t5_tid", transaction_id, 4'd9);
        repeat (15) tick();
        chk("t5_no_timeout_yet", error, 1'b0);
        tick();
        chk("t5_error", error, 1'b1);
        chk("t5_code", err_code, 3'd5);
        finish_txn("t5");

        // T6: async reset mid-burst
        start(4'd4, 8'd3);
        do_beat("t6_b1", 4'd4, 32'h6001, 2'b00, 1'b0, 1'b1, 1'b0);
        chk("t6_count_pre", beat_count, 9'd1);
        rdata = 32'h6002;
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_rst_rready", rready, 1'b0);
        chk("t6_rst_dv", data_valid, 1'b0);
        chk("t6_rst_count", beat_count, 9'd0);
        chk("t6_rst_tid", transaction_id, 4'd0);
        tick();
        resetn = 1'b1;
        rvalid = 1'b0;
        tick();
        chk("t6_restart_tid", transaction_id, 4'd4);
        chk("t6_restart_count", beat_count, 9'd0);
        for (int i = 0; i < 4; i++)
            do_beat("t6_beat", 4'd4, 32'h6100 + i, 2'b00, i == 3, 1'b1, i == 3);
        chk("t6_done", done, 1'b1);
        chk("t6_count", beat_count, 9'd4);
        finish_txn("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
